// File: rtl/video_pal_timing_if.sv
// Purpose: groups the video timing outputs so that pixel sources can take them as one port.
// Latency: none. This is wiring only.
// Backpressure: none. The producer runs freely and consumers just sample.
// Ports:
//   o_sync, o_active   composite sync (0 = sync level) and active-window flag
//   o_x, o_y           active pixel and line index, 0 outside the window
//   o_line_start       one-clock pulse at h==0
//   o_frame_start      one-clock pulse at h==0, v==0
interface video_pal_timing_if;
  logic       o_sync;
  logic       o_active;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       o_line_start;
  logic       o_frame_start;

  modport master (
    output o_sync, o_active, o_x, o_y, o_line_start, o_frame_start
  );

  modport slave (
    input  o_sync, o_active, o_x, o_y, o_line_start, o_frame_start
  );
endinterface

// File: rtl/video_pal_timing.sv
// Purpose: PAL-style 312-line progressive timing generator. It produces composite sync, the active window and x/y.
// Latency: 1 clock. Every output is the registered decode of (h,v) from the previous clock.
// Backpressure: none. The counters run freely after reset.
// Ports:
//   clk   system clock (~12 MHz)
//   rst   asynchronous reset, active high. It forces h=v=0, o_sync=1 and all other outputs to 0.
//   vid   master side of video_pal_timing_if (o_sync, o_active, o_x, o_y, o_line_start, o_frame_start)
module video_pal_timing #(
  parameter int H_TOTAL     = 768,
  parameter int H_SYNC      = 56,
  parameter int H_EQ        = 28,
  parameter int H_ACT_START = 126,
  parameter int H_ACTIVE    = 624,
  parameter int V_TOTAL     = 312,
  parameter int V_BROAD     = 3,
  parameter int V_EQ        = 3,
  parameter int V_ACT_START = 23,
  parameter int V_ACTIVE    = 280
) (
  input  logic               clk,
  input  logic               rst,
  video_pal_timing_if.master vid
);

  localparam int HALF = H_TOTAL / 2;

  // The constants are sized to the counter widths so that every compare below has matching operands.
  localparam logic [9:0] HT_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HALF_W    = 10'(HALF);
  localparam logic [9:0] BROAD_LOW = 10'(HALF - H_SYNC);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] H_EQ_W    = 10'(H_EQ);
  localparam logic [9:0] H_AS      = 10'(H_ACT_START);
  localparam logic [9:0] H_AE      = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [8:0] VT_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_BROAD_W = 9'(V_BROAD);
  localparam logic [8:0] V_EQ_END  = 9'(V_BROAD + V_EQ);
  localparam logic [8:0] V_EQ_TAIL = 9'(V_TOTAL - V_EQ);
  localparam logic [8:0] V_AS      = 9'(V_ACT_START);
  localparam logic [8:0] V_AE      = 9'(V_ACT_START + V_ACTIVE);

  typedef enum logic [1:0] {
    LINE_NORMAL,
    LINE_BROAD,
    LINE_EQ
  } line_type_e;

  logic [9:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       sync_q, sync_d;
  logic       active_q, active_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  logic [9:0] hp;
  line_type_e line_type;
  logic       sync_low;

  always_comb begin
    h_d           = h_q + 10'd1;
    v_d           = v_q;
    hp            = h_q;
    line_type     = LINE_NORMAL;
    sync_low      = 1'b0;
    active_d      = 1'b0;
    x_d           = '0;
    y_d           = '0;

    if (h_q == HT_LAST) begin
      h_d = '0;
      v_d = (v_q == VT_LAST) ? '0 : v_q + 9'd1;
    end

    // Broad and equalising pulses repeat every half line, so they are decoded from the position within the half line.
    if (h_q >= HALF_W) begin
      hp = h_q - HALF_W;
    end

    if (v_q < V_BROAD_W) begin
      line_type = LINE_BROAD;
    end else if (v_q < V_EQ_END || v_q >= V_EQ_TAIL) begin
      line_type = LINE_EQ;
    end

    case (line_type)
      LINE_BROAD: sync_low = (hp < BROAD_LOW);
      LINE_EQ:    sync_low = (hp < H_EQ_W);
      default:    sync_low = (h_q < H_SYNC_W);
    endcase

    if (h_q >= H_AS && h_q < H_AE && v_q >= V_AS && v_q < V_AE) begin
      active_d = 1'b1;
      x_d      = h_q - H_AS;
      y_d      = v_q - V_AS;
    end

    sync_d        = ~sync_low;
    line_start_d  = (h_q == '0);
    frame_start_d = (h_q == '0) && (v_q == '0);
  end

  // Reset takes effect at once and drops any partial line. The restart begins at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      sync_q        <= 1'b1;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      sync_q        <= sync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.o_sync        = sync_q;
  assign vid.o_active      = active_q;
  assign vid.o_x           = x_q;
  assign vid.o_y           = y_q;
  assign vid.o_line_start  = line_start_q;
  assign vid.o_frame_start = frame_start_q;

`ifndef SYNTHESIS
  initial begin
    if (H_ACT_START + H_ACTIVE > H_TOTAL)
      $error("video_pal_timing: active window extends past the end of the line");
    if (V_ACT_START + V_ACTIVE > V_TOTAL - V_EQ)
      $error("video_pal_timing: active lines overlap the trailing equalising lines");
    if (V_ACT_START < V_BROAD + V_EQ)
      $error("video_pal_timing: active lines start inside the vertical sync lines");
  end
`endif

endmodule
